// File: rtl/trace_pkg.sv
// Shared types and constants for the write-back trace monitor.
//
// Contents:
//   trace_entry_t - one captured register-file write: {seq, dest, data}, 53 bits
//   PCSRC_*       - encodings of the datapath next-PC select
//   mon_state_t   - monitor FSM states (RUN, FROZEN)
//   isRedirect    - true when a next-PC select leaves the sequential path
package trace_pkg;

  typedef struct packed {
    logic [15:0] seq;
    logic [4:0]  dest;
    logic [31:0] data;
  } trace_entry_t;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JR  = 2'd2;
  localparam logic [1:0] PCSRC_J   = 2'd3;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } mon_state_t;

  // Branches, register jumps and direct jumps all count as a redirect.
  function automatic logic isRedirect(input logic [1:0] pcsrc);
    logic result;
    case (pcsrc)
      PCSRC_SEQ:                  result = 1'b0;
      PCSRC_BR, PCSRC_JR, PCSRC_J: result = 1'b1;
      default:                    result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding captured trace entries.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (empties the FIFO)
//   i_push       - request to store i_pushData
//   i_pushData   - entry to store
//   i_pop        - consumer takes the head entry (ignored while empty)
//   o_head       - head entry; all zeros while empty
//   o_valid      - head entry is present
//   o_full       - FIFO holds DEPTH entries (registered)
//   o_pushOk     - the current push request is accepted this cycle
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  trace_entry_t i_pushData,
  input  logic         i_pop,
  output trace_entry_t o_head,
  output logic         o_valid,
  output logic         o_full,
  output logic         o_pushOk
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t r_mem [DEPTH];
  logic [AW:0]  r_wrPtr;
  logic [AW:0]  r_rdPtr;
  logic         r_full;
  logic         r_empty;

  logic [AW:0]  w_wrNext;
  logic [AW:0]  w_rdNext;
  logic         w_doPop;
  logic         w_doPush;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  always_comb begin
    w_doPop  = i_pop && !r_empty;
    w_doPush = i_push && (!r_full || w_doPop);
    w_wrNext = w_doPush ? r_wrPtr + (AW+1)'(1) : r_wrPtr;
    w_rdNext = w_doPop  ? r_rdPtr + (AW+1)'(1) : r_rdPtr;
  end

  // Pointers carry an extra wrap bit: equal addresses with differing wrap
  // bits means full, identical pointers means empty. Flags are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wrPtr <= w_wrNext;
      r_rdPtr <= w_rdNext;
      r_full  <= (w_wrNext[AW-1:0] == w_rdNext[AW-1:0]) &&
                 (w_wrNext[AW] != w_rdNext[AW]);
      r_empty <= (w_wrNext == w_rdNext);
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
    end
  end

  assign o_head   = r_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
  assign o_valid  = !r_empty;
  assign o_full   = r_full;
  assign o_pushOk = w_doPush;

endmodule

// File: rtl/wb_trace_monitor.sv
// Passive write-back trace and performance monitor for the datapath WB stage.
// Every retiring register write (except to R0) is captured with a sequence
// number into a trace FIFO drained over a valid/ready port; running counters
// track cycles, retired writes, stall cycles and control-flow redirects.
//
// Ports:
//   clk, rst            - shared CPU clock, asynchronous active-high reset
//   en                  - capture and count enable
//   clr                 - synchronous clear of counters, seq, ovf_cnt, frozen
//   wwreg/wdestReg/wbData - WB-stage register write being observed
//   wpcir               - PC/IR write enable, low on a stall cycle
//   pcsrc               - next-PC select, non-zero on a redirect
//   tr_valid/tr_ready   - trace drain handshake
//   tr_seq/tr_dest/tr_data - head trace entry
//   full, frozen        - FIFO full, monitor frozen after a drop
//   ovf_cnt             - saturating count of dropped entries
//   cycles/retired/stalls/redirects - wrapping performance counters
module wb_trace_monitor
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int STOP_ON_OVF = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             wwreg,
  input  logic [4:0]       wdestReg,
  input  logic [31:0]      wbData,
  input  logic             wpcir,
  input  logic [1:0]       pcsrc,
  output logic             tr_valid,
  input  logic             tr_ready,
  output logic [15:0]      tr_seq,
  output logic [4:0]       tr_dest,
  output logic [31:0]      tr_data,
  output logic             full,
  output logic             frozen,
  output logic [15:0]      ovf_cnt,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stalls,
  output logic [CNT_W-1:0] redirects
);

  mon_state_t       r_state;
  logic             r_frozen;
  logic [15:0]      r_seq;
  logic [15:0]      r_ovfCnt;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_stalls;
  logic [CNT_W-1:0] r_redirects;

  logic             w_writeEvt;
  logic             w_running;
  logic             w_push;
  logic             w_pop;
  logic             w_pushOk;
  logic             w_drop;
  logic             w_valid;
  logic             w_full;
  trace_entry_t     w_pushData;
  trace_entry_t     w_head;

  // Writes to R0 never retire anything visible, so they are not events.
  // While frozen nothing is captured; a clear in the same cycle does not
  // block the push, which carries the sequence number from before the clear.
  always_comb begin
    w_writeEvt      = en && wwreg && (wdestReg != 5'd0);
    w_running       = (r_state == RUN);
    w_push          = w_writeEvt && w_running;
    w_pop           = w_valid && tr_ready;
    w_drop          = w_push && !w_pushOk;
    w_pushData.seq  = r_seq;
    w_pushData.dest = wdestReg;
    w_pushData.data = wbData;
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_valid    (w_valid),
    .o_full     (w_full),
    .o_pushOk   (w_pushOk)
  );

  // Monitor FSM with counters. Clear beats everything else in its cycle.
  // The sequence number advances on every event, including drops, so a gap
  // in the drained trace shows exactly where entries were lost. A drop with
  // STOP_ON_OVF set still counts itself before freezing the monitor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_frozen    <= 1'b0;
      r_seq       <= '0;
      r_ovfCnt    <= '0;
      r_cycles    <= '0;
      r_retired   <= '0;
      r_stalls    <= '0;
      r_redirects <= '0;
    end else if (clr) begin
      r_state     <= RUN;
      r_frozen    <= 1'b0;
      r_seq       <= '0;
      r_ovfCnt    <= '0;
      r_cycles    <= '0;
      r_retired   <= '0;
      r_stalls    <= '0;
      r_redirects <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (en) begin
            r_cycles <= r_cycles + CNT_W'(1);
            if (w_writeEvt) begin
              r_retired <= r_retired + CNT_W'(1);
              r_seq     <= r_seq + 16'd1;
            end
            if (!wpcir) begin
              r_stalls <= r_stalls + CNT_W'(1);
            end
            if (isRedirect(pcsrc)) begin
              r_redirects <= r_redirects + CNT_W'(1);
            end
            if (w_drop) begin
              if (r_ovfCnt != 16'hFFFF) begin
                r_ovfCnt <= r_ovfCnt + 16'd1;
              end
              if (STOP_ON_OVF != 0) begin
                r_state  <= FROZEN;
                r_frozen <= 1'b1;
              end
            end
          end
        end
        FROZEN: begin
          r_state  <= FROZEN;
          r_frozen <= 1'b1;
        end
        default: begin
          r_state  <= RUN;
          r_frozen <= 1'b0;
        end
      endcase
    end
  end

  assign tr_valid  = w_valid;
  assign tr_seq    = w_head.seq;
  assign tr_dest   = w_head.dest;
  assign tr_data   = w_head.data;
  assign full      = w_full;
  assign frozen    = r_frozen;
  assign ovf_cnt   = r_ovfCnt;
  assign cycles    = r_cycles;
  assign retired   = r_retired;
  assign stalls    = r_stalls;
  assign redirects = r_redirects;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Self-checking bench for wb_trace_monitor. One instance runs with drops
// counted; a second instance with STOP_ON_OVF set shares every input except
// its enable and checks the freeze behaviour.
module tb_wb_trace_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, enFrz, clr, wwreg, wpcir, tr_ready;
  logic [4:0]  wdestReg;
  logic [31:0] wbData;
  logic [1:0]  pcsrc;

  logic        tr_valid, full, frozen;
  logic [15:0] tr_seq, ovf_cnt;
  logic [4:0]  tr_dest;
  logic [31:0] tr_data, cycles, retired, stalls, redirects;

  logic        fValid, fFull, fFrozen;
  logic [15:0] fSeq, fOvf;
  logic [4:0]  fDest;
  logic [31:0] fData, fCycles, fRetired, fStalls, fRedirects;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic        en;
    logic        wwreg;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        wpcir;
    logic [1:0]  pcsrc;
    logic        ready;
    logic        clr;
    logic        expValid;
    logic [15:0] expSeq;
    logic [4:0]  expDest;
    logic [31:0] expData;
    logic [31:0] expRetired;
    logic [31:0] expCycles;
    logic [31:0] expStalls;
    logic [31:0] expRedirects;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  wb_trace_monitor #(.DEPTH(16), .CNT_W(32), .STOP_ON_OVF(0)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .wwreg(wwreg),
    .wdestReg(wdestReg), .wbData(wbData), .wpcir(wpcir), .pcsrc(pcsrc),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_seq(tr_seq),
    .tr_dest(tr_dest), .tr_data(tr_data), .full(full), .frozen(frozen),
    .ovf_cnt(ovf_cnt), .cycles(cycles), .retired(retired),
    .stalls(stalls), .redirects(redirects)
  );

  wb_trace_monitor #(.DEPTH(16), .CNT_W(32), .STOP_ON_OVF(1)) dutFrz (
    .clk(clk), .rst(rst), .en(enFrz), .clr(clr), .wwreg(wwreg),
    .wdestReg(wdestReg), .wbData(wbData), .wpcir(wpcir), .pcsrc(pcsrc),
    .tr_valid(fValid), .tr_ready(tr_ready), .tr_seq(fSeq),
    .tr_dest(fDest), .tr_data(fData), .full(fFull), .frozen(fFrozen),
    .ovf_cnt(fOvf), .cycles(fCycles), .retired(fRetired),
    .stalls(fStalls), .redirects(fRedirects)
  );

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one table row onto the shared inputs.
  task automatic applyStimulus(input vec_t v);
    en       = v.en;
    wwreg    = v.wwreg;
    wdestReg = v.dest;
    wbData   = v.data;
    wpcir    = v.wpcir;
    pcsrc    = v.pcsrc;
    tr_ready = v.ready;
    clr      = v.clr;
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    en = 1'b0; enFrz = 1'b0; clr = 1'b0; wwreg = 1'b0; wdestReg = 5'd0;
    wbData = 32'd0; wpcir = 1'b1; pcsrc = 2'd0; tr_ready = 1'b0;
  endtask

  initial begin
    // Fields: en wwreg dest data wpcir pcsrc ready clr |
    //         valid seq dest data retired cycles stalls redirects
    vecs[0] = '{1,1,5'd3, 32'h0000_0005,1,2'd0,0,0, 1,16'd0,5'd3, 32'h0000_0005,1,1,0,0};
    vecs[1] = '{1,1,5'd0, 32'hDEAD_BEEF,1,2'd0,0,0, 1,16'd0,5'd3, 32'h0000_0005,1,2,0,0};
    vecs[2] = '{1,1,5'd7, 32'h0000_1234,0,2'd0,0,0, 1,16'd0,5'd3, 32'h0000_0005,2,3,1,0};
    vecs[3] = '{1,0,5'd0, 32'h0000_0000,1,2'd2,1,0, 1,16'd1,5'd7, 32'h0000_1234,2,4,1,1};
    vecs[4] = '{0,1,5'd9, 32'h0000_00AA,0,2'd1,1,0, 0,16'd0,5'd0, 32'h0000_0000,2,4,1,1};
    vecs[5] = '{1,1,5'd31,32'hFFFF_FFFF,1,2'd0,1,0, 1,16'd2,5'd31,32'hFFFF_FFFF,3,5,1,1};
    vecs[6] = '{1,0,5'd0, 32'h0000_0000,1,2'd0,1,0, 0,16'd0,5'd0, 32'h0000_0000,3,6,1,1};
    vecs[7] = '{1,1,5'd4, 32'h0000_0044,1,2'd0,0,1, 1,16'd3,5'd4, 32'h0000_0044,0,0,0,0};
    vecs[8] = '{1,1,5'd5, 32'h0000_0055,1,2'd0,1,0, 1,16'd0,5'd5, 32'h0000_0055,1,1,0,0};
    vecs[9] = '{1,0,5'd0, 32'h0000_0000,1,2'd0,1,0, 0,16'd0,5'd0, 32'h0000_0000,1,2,0,0};

    // Reset state of both instances.
    idleInputs();
    rst = 1'b1;
    #12;
    checkOutput("rst_valid", {31'd0, tr_valid}, 32'd0);
    rst = 1'b0;
    step();
    checkOutput("rst_valid2", {31'd0, tr_valid}, 32'd0);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_frozen", {31'd0, frozen}, 32'd0);
    checkOutput("rst_seq", {16'd0, tr_seq}, 32'd0);
    checkOutput("rst_dest", {27'd0, tr_dest}, 32'd0);
    checkOutput("rst_data", tr_data, 32'd0);
    checkOutput("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
    checkOutput("rst_cycles", cycles, 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    checkOutput("rst_stalls", stalls, 32'd0);
    checkOutput("rst_redirects", redirects, 32'd0);
    checkOutput("rst_f_frozen", {31'd0, fFrozen}, 32'd0);

    // Table: capture, R0 filter, FWFT, pop, enable gating, clear precedence.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, tr_valid}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_seq", i), {16'd0, tr_seq}, {16'd0, vecs[i].expSeq});
      checkOutput($sformatf("vec%0d_dest", i), {27'd0, tr_dest}, {27'd0, vecs[i].expDest});
      checkOutput($sformatf("vec%0d_data", i), tr_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d_retired", i), retired, vecs[i].expRetired);
      checkOutput($sformatf("vec%0d_cycles", i), cycles, vecs[i].expCycles);
      checkOutput($sformatf("vec%0d_stalls", i), stalls, vecs[i].expStalls);
      checkOutput($sformatf("vec%0d_redirects", i), redirects, vecs[i].expRedirects);
    end

    // Overflow: 18 events into a 16-deep FIFO with no draining.
    idleInputs();
    en = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wwreg = 1'b1; wdestReg = 5'((i % 31) + 1); wbData = 32'hA000_0000 + 32'(i);
      step();
    end
    checkOutput("ovf_full", {31'd0, full}, 32'd1);
    checkOutput("ovf_count", {16'd0, ovf_cnt}, 32'd2);
    checkOutput("ovf_retired", retired, 32'd18);
    checkOutput("ovf_head_seq", {16'd0, tr_seq}, 32'd0);
    checkOutput("ovf_frozen", {31'd0, frozen}, 32'd0);

    // Full FIFO with push and pop together: no drop, still full.
    wwreg = 1'b1; wdestReg = 5'd20; wbData = 32'h0000_CAFE; tr_ready = 1'b1;
    step();
    checkOutput("pp_full", {31'd0, full}, 32'd1);
    checkOutput("pp_ovf", {16'd0, ovf_cnt}, 32'd2);
    checkOutput("pp_retired", retired, 32'd19);

    // Drain: seq 1..15 then the entry pushed above (seq 18).
    wwreg = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k < 15) begin
        checkOutput($sformatf("drain%0d_seq", k), {16'd0, tr_seq}, 32'(k + 1));
        checkOutput($sformatf("drain%0d_dest", k), {27'd0, tr_dest}, 32'(((k + 1) % 31) + 1));
        checkOutput($sformatf("drain%0d_data", k), tr_data, 32'hA000_0000 + 32'(k + 1));
      end else begin
        checkOutput("drain_tail_seq", {16'd0, tr_seq}, 32'd18);
        checkOutput("drain_tail_dest", {27'd0, tr_dest}, 32'd20);
        checkOutput("drain_tail_data", tr_data, 32'h0000_CAFE);
      end
      checkOutput($sformatf("drain%0d_valid", k), {31'd0, tr_valid}, 32'd1);
      step();
    end
    checkOutput("drain_empty", {31'd0, tr_valid}, 32'd0);

    // Freeze on first drop in the STOP_ON_OVF instance.
    idleInputs();
    enFrz = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wwreg = 1'b1; wdestReg = 5'((i % 31) + 1); wbData = 32'(i);
      step();
    end
    checkOutput("frz_frozen", {31'd0, fFrozen}, 32'd1);
    checkOutput("frz_retired", fRetired, 32'd17);
    checkOutput("frz_ovf", {16'd0, fOvf}, 32'd1);
    checkOutput("frz_cycles", fCycles, 32'd17);
    for (int i = 0; i < 3; i++) begin
      wwreg = 1'b1; wdestReg = 5'd9; wbData = 32'h9999_0000 + 32'(i);
      step();
    end
    checkOutput("frz_retired_hold", fRetired, 32'd17);
    checkOutput("frz_cycles_hold", fCycles, 32'd17);
    checkOutput("frz_ovf_hold", {16'd0, fOvf}, 32'd1);
    wwreg = 1'b0; tr_ready = 1'b1;
    step();
    tr_ready = 1'b0;
    checkOutput("frz_pop_seq", {16'd0, fSeq}, 32'd1);
    checkOutput("frz_pop_full", {31'd0, fFull}, 32'd0);
    wwreg = 1'b1; wdestReg = 5'd11; wbData = 32'h0000_1111;
    step();
    checkOutput("frz_no_push", {31'd0, fFull}, 32'd0);
    checkOutput("frz_still", {31'd0, fFrozen}, 32'd1);
    wwreg = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    checkOutput("clr_frozen", {31'd0, fFrozen}, 32'd0);
    checkOutput("clr_retired", fRetired, 32'd0);
    checkOutput("clr_cycles", fCycles, 32'd0);
    checkOutput("clr_ovf", {16'd0, fOvf}, 32'd0);
    checkOutput("clr_keeps_fifo", {31'd0, fValid}, 32'd1);

    // Counters over 10 cycles: stalls on cycles 2 and 3, redirect on cycle 6.
    idleInputs();
    en = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      wpcir = !(c == 2 || c == 3);
      pcsrc = (c == 6) ? 2'd1 : 2'd0;
      step();
    end
    wpcir = 1'b1; pcsrc = 2'd0;
    checkOutput("cnt_cycles", cycles, 32'd10);
    checkOutput("cnt_stalls", stalls, 32'd2);
    checkOutput("cnt_redirects", redirects, 32'd1);

    // Asynchronous reset mid-run discards the FIFO at once.
    wwreg = 1'b1; wdestReg = 5'd6; wbData = 32'h0000_0066;
    step();
    wwreg = 1'b0;
    checkOutput("prerst_valid", {31'd0, tr_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", {31'd0, tr_valid}, 32'd0);
    checkOutput("arst_cycles", cycles, 32'd0);
    checkOutput("arst_stalls", stalls, 32'd0);
    checkOutput("arst_redirects", redirects, 32'd0);
    checkOutput("arst_retired", retired, 32'd0);
    checkOutput("arst_data", tr_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    step();
    checkOutput("postrst_valid", {31'd0, tr_valid}, 32'd0);
    checkOutput("postrst_f_valid", {31'd0, fValid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
